// File: rtl/idma_2d_burst_expander.sv
// idma_2d_burst_expander: takes one 2D job (base addresses, 1D length, reps,
// strides) and issues its reps 1D bursts in order to the backend. A small
// FIFO tracks the rep count of every job still outstanding at the backend.
// Backend burst completions are counted against the oldest job. When the
// oldest job is fully done, one trans_complete pulse is emitted.

// Protocol checker: a burst completion must never arrive with no job outstanding.
module idma_2d_burst_expander_chk (
  input logic clk_i,
  input logic rst_i,
  input logic burst_done_i,
  input logic fifo_empty
);

  // Flag a completion pulse that has no tracked job to belong to.
  always @(posedge clk_i) begin
    if (!rst_i && burst_done_i && fifo_empty) begin
      assert (1'b0) else $error("burst_done_i received with no outstanding job");
    end
  end

endmodule

module idma_2d_burst_expander #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned LenWidth  = 32,
  parameter int unsigned RepWidth  = 32,
  parameter int unsigned OptWidth  = 8,
  parameter int unsigned MaxJobs   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_src_addr_i,
  input  logic [AddrWidth-1:0] req_dst_addr_i,
  input  logic [LenWidth-1:0]  req_length_i,
  input  logic [RepWidth-1:0]  req_reps_i,
  input  logic [AddrWidth-1:0] req_src_stride_i,
  input  logic [AddrWidth-1:0] req_dst_stride_i,
  input  logic [OptWidth-1:0]  req_opt_i,
  output logic                 burst_valid_o,
  input  logic                 burst_ready_i,
  output logic [AddrWidth-1:0] burst_src_addr_o,
  output logic [AddrWidth-1:0] burst_dst_addr_o,
  output logic [LenWidth-1:0]  burst_length_o,
  output logic [OptWidth-1:0]  burst_opt_o,
  output logic                 burst_last_o,
  input  logic                 burst_done_i,
  output logic                 trans_complete_o,
  output logic                 busy_o
);

  localparam int unsigned PtrWidth = $clog2(MaxJobs);
  localparam logic [RepWidth-1:0] RepZero = {RepWidth{1'b0}};
  localparam logic [RepWidth-1:0] RepOne  = {{(RepWidth-1){1'b0}}, 1'b1};
  localparam logic [RepWidth-1:0] RepTwo  = {{(RepWidth-2){1'b0}}, 2'b10};
  localparam logic [PtrWidth:0]   PtrOne  = {{PtrWidth{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t               state;
  logic [AddrWidth-1:0] src;
  logic [AddrWidth-1:0] dst;
  logic [AddrWidth-1:0] src_stride;
  logic [AddrWidth-1:0] dst_stride;
  logic [LenWidth-1:0]  len;
  logic [OptWidth-1:0]  opt;
  logic [RepWidth-1:0]  remaining;
  logic                 burst_valid;
  logic                 burst_last;
  logic                 trans_complete;

  logic [RepWidth-1:0]  fifo_mem [MaxJobs];
  logic [PtrWidth:0]    wr_ptr;
  logic [PtrWidth:0]    rd_ptr;
  logic [RepWidth-1:0]  done_cnt;

  logic                 fifo_empty;
  logic                 fifo_full;
  logic [RepWidth-1:0]  head_reps;
  logic [RepWidth-1:0]  eff_reps;
  logic                 req_ready;
  logic                 accept;
  logic                 burst_hs;
  logic                 job_done;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PtrWidth] != rd_ptr[PtrWidth]) &&
                      (wr_ptr[PtrWidth-1:0] == rd_ptr[PtrWidth-1:0]);
  assign head_reps  = fifo_mem[rd_ptr[PtrWidth-1:0]];

  // A zero repetition count still means one burst.
  assign eff_reps  = (req_reps_i == RepZero) ? RepOne : req_reps_i;

  // Ready comes from registered state only. It never depends on req_valid_i.
  assign req_ready = (state == IDLE) && !fifo_full && !rst_i;
  assign accept    = req_valid_i && req_ready;
  assign burst_hs  = burst_valid && burst_ready_i;

  // The completion that finishes the oldest outstanding job.
  assign job_done  = burst_done_i && !fifo_empty && ((done_cnt + RepOne) == head_reps);

  // Job issue FSM: latch the job on accept, then walk the reps bursts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      src         <= {AddrWidth{1'b0}};
      dst         <= {AddrWidth{1'b0}};
      src_stride  <= {AddrWidth{1'b0}};
      dst_stride  <= {AddrWidth{1'b0}};
      len         <= {LenWidth{1'b0}};
      opt         <= {OptWidth{1'b0}};
      remaining   <= RepZero;
      burst_valid <= 1'b0;
      burst_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            src         <= req_src_addr_i;
            dst         <= req_dst_addr_i;
            src_stride  <= req_src_stride_i;
            dst_stride  <= req_dst_stride_i;
            len         <= req_length_i;
            opt         <= req_opt_i;
            remaining   <= eff_reps;
            burst_valid <= 1'b1;
            burst_last  <= (eff_reps == RepOne);
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (burst_hs) begin
            // Address arithmetic wraps modulo 2^AddrWidth. A negative stride is two's complement.
            src        <= src + src_stride;
            dst        <= dst + dst_stride;
            remaining  <= remaining - RepOne;
            burst_last <= (remaining == RepTwo);
            if (burst_last) begin
              burst_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          burst_valid <= 1'b0;
          burst_last  <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Tracker storage: record each accepted job's effective rep count.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_mem[wr_ptr[PtrWidth-1:0]] <= eff_reps;
    end
  end

  // Tracker pointers: push on accept, pop when the head job completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= {(PtrWidth+1){1'b0}};
      rd_ptr <= {(PtrWidth+1){1'b0}};
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PtrOne;
      end
      if (job_done) begin
        rd_ptr <= rd_ptr + PtrOne;
      end
    end
  end

  // Completion counting against the head job, plus the registered retire pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_cnt       <= RepZero;
      trans_complete <= 1'b0;
    end else begin
      trans_complete <= job_done;
      if (job_done) begin
        done_cnt <= RepZero;
      end else if (burst_done_i && !fifo_empty) begin
        done_cnt <= done_cnt + RepOne;
      end
    end
  end

  // Every output reads as zero while reset is held.
  assign req_ready_o      = req_ready;
  assign burst_valid_o    = burst_valid && !rst_i;
  assign burst_last_o     = burst_last && !rst_i;
  assign burst_src_addr_o = rst_i ? {AddrWidth{1'b0}} : src;
  assign burst_dst_addr_o = rst_i ? {AddrWidth{1'b0}} : dst;
  assign burst_length_o   = rst_i ? {LenWidth{1'b0}} : len;
  assign burst_opt_o      = rst_i ? {OptWidth{1'b0}} : opt;
  assign trans_complete_o = trans_complete && !rst_i;
  assign busy_o           = ((state == ISSUE) || !fifo_empty) && !rst_i;

  idma_2d_burst_expander_chk u_chk (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .burst_done_i (burst_done_i),
    .fifo_empty   (fifo_empty)
  );

endmodule

// File: tb/tb_idma_2d_burst_expander.sv
// Scoreboard bench for idma_2d_burst_expander. Stimulus pushes hand-computed
// bursts and completion times into queues. Negedge monitors pop and compare.
module tb_idma_2d_burst_expander;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_src, req_dst, req_len, req_reps, req_ss, req_ds;
  logic [7:0]  req_opt;
  logic        burst_valid;
  logic        burst_ready;
  logic [31:0] burst_src, burst_dst, burst_len;
  logic [7:0]  burst_opt;
  logic        burst_last;
  logic        burst_done;
  logic        trans_complete;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic [7:0]  opt;
    logic        last;
  } burst_t;

  burst_t exp_bursts[$];
  int     exp_trans[$];
  burst_t mon_e;
  int     mon_c;

  idma_2d_burst_expander dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_src_addr_i   (req_src),
    .req_dst_addr_i   (req_dst),
    .req_length_i     (req_len),
    .req_reps_i       (req_reps),
    .req_src_stride_i (req_ss),
    .req_dst_stride_i (req_ds),
    .req_opt_i        (req_opt),
    .burst_valid_o    (burst_valid),
    .burst_ready_i    (burst_ready),
    .burst_src_addr_o (burst_src),
    .burst_dst_addr_o (burst_dst),
    .burst_length_o   (burst_len),
    .burst_opt_o      (burst_opt),
    .burst_last_o     (burst_last),
    .burst_done_i     (burst_done),
    .trans_complete_o (trans_complete),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp expected completion pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0b, expected %0b", name, act, expv);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_b(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                        input logic [7:0] o, input logic last);
    burst_t b;
    b.src = s; b.dst = d; b.len = l; b.opt = o; b.last = last;
    exp_bursts.push_back(b);
  endtask

  task automatic send_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                          input logic [31:0] r, input logic [31:0] ss, input logic [31:0] ds,
                          input logic [7:0] o);
    int n;
    req_src = s; req_dst = d; req_len = l; req_reps = r;
    req_ss = ss; req_ds = ds; req_opt = o; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) timeout_fail("job_accept");
    step();
    req_valid = 1'b0;
  endtask

  task automatic done_pulse(input bit completes);
    burst_done = 1'b1;
    if (completes) exp_trans.push_back(cyc + 1);
    step();
    burst_done = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_bursts.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) timeout_fail("burst_drain");
  endtask

  // Burst monitor: each handshaking burst must match the next expected one.
  always @(negedge clk) begin
    if (!rst && burst_valid && burst_ready) begin
      vectors++;
      if (exp_bursts.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_burst: got src 0x%0h dst 0x%0h, expected no burst", burst_src, burst_dst);
      end else begin
        mon_e = exp_bursts.pop_front();
        if (burst_src !== mon_e.src || burst_dst !== mon_e.dst || burst_len !== mon_e.len ||
            burst_opt !== mon_e.opt || burst_last !== mon_e.last) begin
          miscompares++;
          $display("FAIL burst: got src 0x%0h dst 0x%0h len %0d opt 0x%0h last %0b, expected src 0x%0h dst 0x%0h len %0d opt 0x%0h last %0b",
                   burst_src, burst_dst, burst_len, burst_opt, burst_last,
                   mon_e.src, mon_e.dst, mon_e.len, mon_e.opt, mon_e.last);
        end
      end
    end
  end

  // Completion monitor: each trans_complete pulse must land on its expected cycle.
  always @(negedge clk) begin
    if (!rst && trans_complete) begin
      if (exp_trans.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_trans_complete: got pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_c = exp_trans.pop_front();
        check_word("trans_complete_cycle", cyc, mon_c);
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_src = 32'h0; req_dst = 32'h0; req_len = 32'h0;
    req_reps = 32'h0; req_ss = 32'h0; req_ds = 32'h0; req_opt = 8'h0;
    burst_ready = 1'b1; burst_done = 1'b0;
    repeat (3) step();
    check_bit("rst_req_ready", req_ready, 1'b0);
    check_bit("rst_burst_valid", burst_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_trans", trans_complete, 1'b0);
    check_word("rst_src", burst_src, 32'h0);
    rst = 1'b0;
    #1;
    check_bit("release_req_ready", req_ready, 1'b1);

    // 1D job
    push_b(32'h1000, 32'h2000, 32'd64, 8'h11, 1'b1);
    send_job(32'h1000, 32'h2000, 32'd64, 32'd1, 32'h0, 32'h0, 8'h11);
    check_bit("1d_latency_valid", burst_valid, 1'b1);
    wait_drain();
    step();
    check_bit("1d_busy_outstanding", busy, 1'b1);
    done_pulse(1'b1);
    check_bit("1d_busy_drop", busy, 1'b0);
    step();

    // 2D job, 3 reps
    push_b(32'h1000, 32'h2000, 32'd32, 8'h22, 1'b0);
    push_b(32'h1100, 32'h2040, 32'd32, 8'h22, 1'b0);
    push_b(32'h1200, 32'h2080, 32'd32, 8'h22, 1'b1);
    send_job(32'h1000, 32'h2000, 32'd32, 32'd3, 32'h100, 32'h40, 8'h22);
    wait_drain();
    done_pulse(1'b0);
    done_pulse(1'b0);
    step();
    check_bit("2d_no_early_trans", trans_complete, 1'b0);
    done_pulse(1'b1);
    step();

    // Backpressure mid-job
    burst_ready = 1'b0;
    push_b(32'h4000, 32'h5000, 32'd16, 8'h5A, 1'b0);
    push_b(32'h4010, 32'h5020, 32'd16, 8'h5A, 1'b0);
    push_b(32'h4020, 32'h5040, 32'd16, 8'h5A, 1'b0);
    push_b(32'h4030, 32'h5060, 32'd16, 8'h5A, 1'b1);
    send_job(32'h4000, 32'h5000, 32'd16, 32'd4, 32'h10, 32'h20, 8'h5A);
    burst_ready = 1'b1;
    step();
    burst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_bit("bp_valid_held", burst_valid, 1'b1);
      check_word("bp_src_held", burst_src, 32'h4010);
      check_word("bp_dst_held", burst_dst, 32'h5020);
      check_bit("bp_last_held", burst_last, 1'b0);
      check_bit("bp_req_ready_low", req_ready, 1'b0);
    end
    burst_ready = 1'b1;
    wait_drain();
    done_pulse(1'b0);
    done_pulse(1'b0);
    done_pulse(1'b0);
    done_pulse(1'b1);
    step();

    // Address wrap
    push_b(32'hFFFFFF00, 32'h0, 32'd8, 8'h00, 1'b0);
    push_b(32'h00000000, 32'h4, 32'd8, 8'h00, 1'b1);
    send_job(32'hFFFFFF00, 32'h0, 32'd8, 32'd2, 32'h100, 32'h4, 8'h00);
    wait_drain();
    done_pulse(1'b0);
    done_pulse(1'b1);
    step();

    // reps = 0 behaves as one burst
    push_b(32'h3000, 32'h3800, 32'd128, 8'h80, 1'b1);
    send_job(32'h3000, 32'h3800, 32'd128, 32'd0, 32'h10, 32'h10, 8'h80);
    wait_drain();
    step();
    step();
    check_bit("reps0_single_burst", burst_valid, 1'b0);
    done_pulse(1'b1);
    step();

    // Tracker full
    for (int i = 0; i < 4; i++) begin
      push_b(32'h6000 + i * 32'h100, 32'h6800 + i * 32'h100, 32'd4, 8'h01, 1'b1);
      send_job(32'h6000 + i * 32'h100, 32'h6800 + i * 32'h100, 32'd4, 32'd1, 32'h0, 32'h0, 8'h01);
      wait_drain();
    end
    step();
    step();
    check_bit("full_req_ready_low", req_ready, 1'b0);
    check_bit("full_idle_no_burst", burst_valid, 1'b0);
    check_bit("full_busy", busy, 1'b1);
    push_b(32'h7000, 32'h7800, 32'd4, 8'h0F, 1'b1);
    req_src = 32'h7000; req_dst = 32'h7800; req_len = 32'd4; req_reps = 32'd1;
    req_ss = 32'h0; req_ds = 32'h0; req_opt = 8'h0F; req_valid = 1'b1;
    burst_done = 1'b1;
    exp_trans.push_back(cyc + 1);
    step();
    burst_done = 1'b0;
    check_bit("full_no_accept_at_pop", burst_valid, 1'b0);
    check_bit("full_ready_after_pop", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    check_bit("full_job_accepted", burst_valid, 1'b1);
    wait_drain();
    for (int i = 0; i < 4; i++) done_pulse(1'b1);
    step();

    // Reset mid-job
    burst_ready = 1'b0;
    push_b(32'h8000, 32'h9000, 32'd16, 8'h00, 1'b0);
    send_job(32'h8000, 32'h9000, 32'd16, 32'd3, 32'h20, 32'h20, 8'h00);
    burst_ready = 1'b1;
    step();
    burst_ready = 1'b0;
    rst = 1'b1;
    step();
    check_bit("midrst_valid", burst_valid, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    burst_ready = 1'b1;
    repeat (3) step();
    check_bit("postrst_busy", busy, 1'b0);
    check_bit("postrst_ready", req_ready, 1'b1);
    push_b(32'hA000, 32'hB000, 32'd64, 8'h33, 1'b1);
    send_job(32'hA000, 32'hB000, 32'd64, 32'd1, 32'h0, 32'h0, 8'h33);
    wait_drain();
    done_pulse(1'b1);
    repeat (3) step();

    check_word("leftover_bursts", exp_bursts.size(), 32'd0);
    check_word("leftover_trans", exp_trans.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/idma_2d_burst_expander.md
Name: idma_2d_burst_expander

Overview:
- Consumer side of the frontend-to-backend 2D burst request interface.
- Accepts one 2D job per valid/ready handshake: base addresses, 1D length, repetition count, strides.
- Emits the job's reps 1D bursts, in order, to the 1D backend.
- Counts the backend's per-burst completions and emits one trans_complete pulse per finished 2D job, which drives the frontend's transfer-ID retire path.

Parameters:
- AddrWidth, 32, width of address and stride fields.
- LenWidth, 32, width of the 1D length field.
- RepWidth, 32, width of the repetition count.
- OptWidth, 8, opaque option bits (decouple/deburst etc.), passed through unchanged.
- MaxJobs, 4, depth of the completion-tracking FIFO (2D jobs outstanding at the backend); power of 2, at least 2.

Ports:
- clk_i in 1: clock, all state on the rising edge.
- rst_i in 1: reset, synchronous, active-high.
- req_valid_i in 1: 2D job valid.
- req_ready_o out 1: 2D job accepted when valid and ready are both high.
- req_src_addr_i in AddrWidth: source base address.
- req_dst_addr_i in AddrWidth: destination base address.
- req_length_i in LenWidth: bytes per 1D burst.
- req_reps_i in RepWidth: number of 1D bursts; 0 is treated as 1.
- req_src_stride_i in AddrWidth: source increment per repetition.
- req_dst_stride_i in AddrWidth: destination increment per repetition.
- req_opt_i in OptWidth: option bits.
- burst_valid_o out 1: 1D burst valid.
- burst_ready_i in 1: backend accepts the 1D burst.
- burst_src_addr_o out AddrWidth: 1D source address.
- burst_dst_addr_o out AddrWidth: 1D destination address.
- burst_length_o out LenWidth: 1D length.
- burst_opt_o out OptWidth: option bits.
- burst_last_o out 1: marks the final 1D burst of a job.
- burst_done_i in 1: single-cycle pulse, one per completed 1D burst; completions arrive in issue order.
- trans_complete_o out 1: single-cycle pulse per completed 2D job.
- busy_o out 1: high while a job is being issued or any job is outstanding.

Behaviour:
- Reset, while rst_i is high:
  - All outputs 0; req_ready_o is forced to 0.
  - FSM goes to IDLE; tracker FIFO and completion counter are cleared.
- Reset mid-operation discards all in-flight and outstanding jobs; no trans_complete_o is generated for them.
- FSM states: IDLE and ISSUE.
- IDLE:
  - req_ready_o = !rst_i && !fifo_full; it is combinational from registered state only and never depends on req_valid_i.
  - On accept: register addresses, length, opt and strides; remaining = (reps==0 ? 1 : reps); push the same effective reps into the tracker FIFO; go to ISSUE.
- ISSUE:
  - req_ready_o = 0.
  - burst_valid_o = 1, driven from registers; first burst appears the cycle after accept (latency 1).
  - burst_last_o = (remaining == 1).
  - All burst_* outputs are held stable while burst_ready_i is low.
  - On handshake: src += src_stride and dst += dst_stride, each modulo 2^AddrWidth (wrap, no error); remaining -= 1.
  - If the handshaken burst had burst_last_o = 1, go to IDLE.
- A new job can be accepted no earlier than the cycle after the last burst handshake: one bubble cycle between jobs.
- Completion tracking:
  - done_cnt counts burst_done_i pulses against the FIFO head's reps.
  - When a burst_done_i arrives with done_cnt+1 == head_reps: pop the head, clear done_cnt, and pulse trans_complete_o in the following cycle (registered).
  - Otherwise burst_done_i only increments done_cnt.
- Simultaneous FIFO push (accept) and pop (completion) in one cycle is legal and leaves the occupancy unchanged.
- A full FIFO blocks acceptance even if the FSM is in IDLE.
- burst_done_i while the FIFO is empty is a protocol violation: the event is ignored and a simulation assertion fires.
- busy_o = (state == ISSUE) || !fifo_empty, registered-state derived.
- Widths: done_cnt and remaining are RepWidth bits. Strides are added unsigned; a negative stride is two's-complement wrap.

Test Plan:
- 1D job: src 0x1000, dst 0x2000, len 64, reps 1 -> exactly one burst the cycle after accept with last=1 and length 64; one burst_done_i -> trans_complete_o pulses 1 cycle later; busy_o then drops to 0.
- 2D job: reps 3, src_stride 0x100, dst_stride 0x40 -> bursts (src, dst) = (0x1000, 0x2000), (0x1100, 0x2040), (0x1200, 0x2080); last only on the third; trans_complete_o only after the third burst_done_i.
- Backpressure: burst_ready_i low for 5 cycles mid-job -> burst outputs constant throughout; req_ready_o stays 0.
- Tracker full: MaxJobs=4 and 4 one-rep jobs issued with no burst_done_i -> req_ready_o=0 with the FSM in IDLE; a done pulse arriving together with a new offered job -> 1 trans_complete_o, and that job is accepted the cycle after the pop.
- Edge values:
  - src 0xFFFFFF00, stride 0x100, reps 2 -> second src 0x00000000.
  - reps 0 -> exactly one burst with last=1, and one trans_complete_o.
- Reset mid-job: rst_i asserted during the second of 3 bursts -> next cycle burst_valid_o=0, busy_o=0, no trans_complete_o; a fresh job after reset behaves normally.
